th_flt_seq: RTL and testbench
=============================

// Module: th_flt_seq
// PURPOSE
//  Sequencer for the nibble-serial threshold filter. Accepts 8-bit samples (valid/ready) and
//  8-bit threshold updates, then drives the filter's 4-bit load bus and {threshold,Higher} selects.
//  Loads a default threshold automatically after reset and counts peak events from the peak
//  detector. Sits between the sample source and the threshold filter in the heart-signal path.
// PARAMETERS
//  TH_DEFAULT  8'h80  threshold auto-loaded after every reset
//  PCW         8      peak counter width (saturating)
// PORTS
//  clk        in   1    system clock; all state on posedge
//  rst        in   1    asynchronous active-low reset
//  smp_valid  in   1    sample offered
//  smp_data   in   8    sample value
//  smp_ready  out  1    sample accepted when smp_valid & smp_ready
//  th_wr      in   1    one-cycle threshold write strobe
//  th_data    in   8    new threshold
//  nib_out    out  4    filter load bus
//  sel_th     out  1    filter 'threshold' select
//  sel_hi     out  1    filter 'Higher' select
//  busy       out  1    state != IDLE or threshold pending
//  smp_done   out  1    1-cycle pulse, cycle after a sample's high nibble is presented
//  peak_in    in   1    peak level from peak detector (multi-cycle level)
//  peak_clr   in   1    synchronous clear of peak counter
//  peak_cnt   out  PCW  peak event count
// BEHAVIOUR
//  FSM: IDLE, TH_LO, TH_HI, IN_LO, IN_HI. Selects/nibble are Moore outputs of the state:
//   IDLE  sel=00 nib=smp_q[3:0] (re-writes same inst low nibble; harmless)
//   IN_LO sel=00 nib=smp_q[3:0];  IN_HI sel=01 nib=smp_q[7:4]
//   TH_LO sel=10 nib=th_q[3:0];   TH_HI sel=11 nib=th_q[7:4]
//  Transitions: IDLE->TH_LO if th_pend; else IDLE->IN_LO on accept. TH_LO->TH_HI->IDLE;
//   IN_LO->IN_HI->IDLE. Threshold has priority over samples.
//  smp_ready = (state==IDLE) & ~th_pend. Accept latches smp_data into smp_q. Sample throughput
//   one per 3 cycles; smp_done asserts the cycle after IN_HI.
//  th_wr: any state, any cycle; th_q<=th_data, th_pend<=1 (latest write wins). th_pend cleared
//   on TH_HI exit unless th_wr in that same cycle (then stays 1, new value reloaded).
//  th_wr with accept in same cycle: sample proceeds first (ready uses registered th_pend),
//   threshold loads right after.
//  Reset (async, any time incl. mid-sequence): state=IDLE, smp_q=0, th_q=TH_DEFAULT, th_pend=1,
//   smp_done=0, peak_cnt=0; outputs: nib_out=0, sel=00, smp_ready=0, busy=1. First two cycles
//   after release load TH_DEFAULT; smp_ready first rises in the 3rd cycle.
//  Filter latches inst/th on posedge; it compares on negedge while sel_hi=1, so new result is
//   valid mid-IN_HI cycle.
// CONFIGURATION
//  PEAK_CNT_EN defined: peak_in double-flopped, rising edge increments peak_cnt, saturates at
//   2^PCW-1; peak_clr wins over simultaneous increment.
//  PEAK_CNT_EN undefined: no sync/counter logic; peak_cnt tied to 0; peak_in/peak_clr ignored.
// STRUCTURE
//  th_flt_pkg: FSM state encoding, SEL_IN_LO=2'b00, SEL_IN_HI=2'b01, SEL_TH_LO=2'b10,
//   SEL_TH_HI=2'b11 constants.
//  One sub-module: pk_cnt (synchroniser + edge detect + saturating counter), instantiated only
//   under PEAK_CNT_EN.
// TESTING
//  Reset release -> cycles 1,2: sel=10 nib=0, sel=11 nib=8; smp_ready=1 cycle 3.
//  smp_data=8'hA5 accepted -> nib 5 sel=00, then nib A sel=01, smp_done next cycle; filter inst=A5.
//  th_wr 8'h3C and smp_valid same IDLE cycle -> sample IN_LO/IN_HI first, then TH_LO nib C, TH_HI nib 3.
//  Two th_wr (8'h11 then 8'h22) while busy -> only 8'h22 loaded, one TH sequence.
//  Reset asserted in IN_HI -> outputs to reset values at once; TH_DEFAULT reload after release.
//  PEAK_CNT_EN, PCW=2: 5 peak_in pulses (each 4 cycles) -> peak_cnt 1,2,3,3,3; peak_clr -> 0.

Source files
------------

// File: rtl/th_flt_pkg.sv
// Shared definitions for the threshold-filter sequencer: FSM states and filter select codes.
package th_flt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TH_LO = 3'd1,
    TH_HI = 3'd2,
    IN_LO = 3'd3,
    IN_HI = 3'd4
  } state_t;

  // {threshold, Higher} select pairs driven to the filter
  localparam logic [1:0] SEL_IN_LO = 2'b00;
  localparam logic [1:0] SEL_IN_HI = 2'b01;
  localparam logic [1:0] SEL_TH_LO = 2'b10;
  localparam logic [1:0] SEL_TH_HI = 2'b11;

endpackage

// File: rtl/th_flt_seq_pk_cnt.sv
// Peak event counter: double-flop synchroniser, rising-edge detect, saturating count.
// Only instantiated when PEAK_CNT_EN is defined.
module pk_cnt #(
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           peak_in,
  input  logic           peak_clr,
  output logic [PCW-1:0] peak_cnt
);

  logic sync1, sync2, sync_prev;
  logic rise;

  assign rise = sync2 & ~sync_prev;

  // Clear wins over a simultaneous edge; the count holds once it reaches all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      peak_cnt  <= '0;
    end else begin
      sync1     <= peak_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (peak_clr)
        peak_cnt <= '0;
      else if (rise && (peak_cnt != {PCW{1'b1}}))
        peak_cnt <= peak_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/th_flt_seq.sv
// Sequencer for the nibble-serial threshold filter: serialises samples and thresholds onto the
// 4-bit load bus. Optional peak counter enabled by defining PEAK_CNT_EN.
module th_flt_seq
  import th_flt_pkg::*;
#(
  parameter logic [7:0] TH_DEFAULT = 8'h80,
  parameter int         PCW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           smp_valid,
  input  logic [7:0]     smp_data,
  output logic           smp_ready,
  input  logic           th_wr,
  input  logic [7:0]     th_data,
  output logic [3:0]     nib_out,
  output logic           sel_th,
  output logic           sel_hi,
  output logic           busy,
  output logic           smp_done,
  input  logic           peak_in,
  input  logic           peak_clr,
  output logic [PCW-1:0] peak_cnt
);

  state_t     state_q, state_d;
  logic [7:0] smp_q;
  logic [7:0] th_q;
  logic       th_pend;
  logic [1:0] sel;
  logic       accept;

  // Ready looks only at registered pending flag, so a same-cycle th_wr lets the sample go first
  assign smp_ready = (state_q == IDLE) & ~th_pend;
  assign accept    = smp_valid & smp_ready;
  assign busy      = (state_q != IDLE) | th_pend;
  assign sel_th    = sel[1];
  assign sel_hi    = sel[0];

  always_comb begin
    state_d = state_q;
    sel     = SEL_IN_LO;
    nib_out = smp_q[3:0];
    case (state_q)
      IDLE: begin
        if (th_pend)
          state_d = TH_LO;
        else if (accept)
          state_d = IN_LO;
      end
      TH_LO: begin
        sel     = SEL_TH_LO;
        nib_out = th_q[3:0];
        state_d = TH_HI;
      end
      TH_HI: begin
        sel     = SEL_TH_HI;
        nib_out = th_q[7:4];
        state_d = IDLE;
      end
      IN_LO: begin
        sel     = SEL_IN_LO;
        nib_out = smp_q[3:0];
        state_d = IN_HI;
      end
      IN_HI: begin
        sel     = SEL_IN_HI;
        nib_out = smp_q[7:4];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing in the TH_HI cycle keeps the flag set so the new value is loaded again
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      smp_q    <= '0;
      th_q     <= TH_DEFAULT;
      th_pend  <= 1'b1;
      smp_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        smp_q <= smp_data;
      if (th_wr) begin
        th_q    <= th_data;
        th_pend <= 1'b1;
      end else if (state_q == TH_HI) begin
        th_pend <= 1'b0;
      end
      smp_done <= (state_q == IN_HI);
    end
  end

`ifdef PEAK_CNT_EN
  pk_cnt #(
    .PCW(PCW)
  ) u_pk_cnt (
    .clk      (clk),
    .rst      (rst),
    .peak_in  (peak_in),
    .peak_clr (peak_clr),
    .peak_cnt (peak_cnt)
  );
`else
  logic unused_peak;
  assign unused_peak = peak_in ^ peak_clr;
  assign peak_cnt    = '0;
`endif

endmodule

// File: tb/tb_th_flt_seq.sv
// Scoreboard bench for th_flt_seq: a job-level model predicts each byte delivered to the filter
// and a monitor reassembles nibble pairs from the load bus and compares.
module tb_th_flt_seq;

  localparam int         PCW = 2;
  localparam logic [7:0] THD = 8'h80;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           smp_valid = 1'b0;
  logic [7:0]     smp_data = '0;
  logic           smp_ready;
  logic           th_wr = 1'b0;
  logic [7:0]     th_data = '0;
  logic [3:0]     nib_out;
  logic           sel_th, sel_hi, busy, smp_done;
  logic           peak_in = 1'b0;
  logic           peak_clr = 1'b0;
  logic [PCW-1:0] peak_cnt;

  th_flt_seq #(.TH_DEFAULT(THD), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .th_wr(th_wr), .th_data(th_data), .nib_out(nib_out), .sel_th(sel_th), .sel_hi(sel_hi),
    .busy(busy), .smp_done(smp_done), .peak_in(peak_in), .peak_clr(peak_clr),
    .peak_cnt(peak_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       kind;
    logic [7:0] val;
  } exp_t;
  exp_t expQ[$];

  // Job-level reference: jobSlot 0 = free, 1/2 = first/second half of a two-nibble transfer
  int         jobSlot;
  logic       jobIsTh;
  logic       mPend;
  logic [7:0] mTh;
  logic [3:0] mThLo;
  logic       mDone;
  logic [7:0] newTh;
  logic       freePre;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic w,
                               input logic [7:0] t);
    @(negedge clk);
    smp_valid = v;
    smp_data  = d;
    th_wr     = w;
    th_data   = t;
  endtask

  task automatic resetModel();
    jobSlot = 0;
    jobIsTh = 1'b0;
    mPend   = 1'b1;
    mTh     = THD;
    mThLo   = '0;
    mDone   = 1'b0;
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_nib"}, nib_out, 0);
    checkOutput({tag, "_sel"}, {sel_th, sel_hi}, 0);
    checkOutput({tag, "_ready"}, smp_ready, 0);
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_done"}, smp_done, 0);
    checkOutput({tag, "_peak"}, peak_cnt, 0);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(jobSlot == 0 && !mPend && expQ.size() == 0) && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("idle_reached", (n < 100), 1);
  endtask

  // Reference model: a free engine takes a pending threshold first, else an offered sample
  initial begin
    resetModel();
    forever begin
      @(posedge clk);
      if (rst) begin
        freePre = (jobSlot == 0) && !mPend;
        newTh   = th_wr ? th_data : mTh;
        mDone   = (jobSlot == 2) && !jobIsTh;
        case (jobSlot)
          0: begin
            if (mPend) begin
              jobIsTh = 1'b1;
              mThLo   = newTh[3:0];
              jobSlot = 1;
            end else if (smp_valid && freePre) begin
              jobIsTh = 1'b0;
              expQ.push_back('{1'b0, smp_data});
              jobSlot = 1;
            end
          end
          1: begin
            if (jobIsTh) expQ.push_back('{1'b1, {newTh[7:4], mThLo}});
            jobSlot = 2;
          end
          default: begin
            if (jobIsTh && !th_wr) mPend = 1'b0;
            jobSlot = 0;
          end
        endcase
        if (th_wr) mPend = 1'b1;
        mTh = newTh;
      end
    end
  end

  // Monitor: low nibble is remembered, high-nibble cycle completes one byte transfer
  logic [3:0] lastLo = '0;
  logic       lastTh = 1'b0;
  exp_t       e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("smp_ready", smp_ready, (jobSlot == 0) && !mPend);
        checkOutput("busy", busy, (jobSlot != 0) || mPend);
        checkOutput("smp_done", smp_done, mDone);
        if (sel_hi) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL xfer_unexpected: got %0h expected none", {lastTh, sel_th, nib_out, lastLo});
          end else begin
            e = expQ.pop_front();
            checkOutput("xfer", {lastTh, sel_th, nib_out, lastLo}, {e.kind, e.kind, e.val});
          end
        end else begin
          lastLo = nib_out;
          lastTh = sel_th;
        end
      end
    end
  end

  int k;
  int expPk;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    rst = 1'b1;
    waitIdle();

    // Single sample, then sample and threshold offered together, then two coalesced writes
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    waitIdle();
    applyStimulus(1'b1, 8'h5A, 1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    waitIdle();
    applyStimulus(1'b1, 8'h96, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    waitIdle();

    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                    8'($urandom));
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    waitIdle();

    // Reset while a sample's high nibble is on the bus
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    n = 0;
    while (!(jobSlot == 2 && !jobIsTh) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_in_hi", (n < 20), 1);
    #2;
    rst = 1'b0;
    resetModel();
    #1;
    checkResetOutputs("mid");
    @(negedge clk);
    rst = 1'b1;
    waitIdle();

    // Peak pulses: saturating count, then synchronous clear
    for (k = 1; k <= 5; k++) begin
      repeat (4) @(negedge clk) peak_in = 1'b1;
      repeat (5) @(negedge clk) peak_in = 1'b0;
`ifdef PEAK_CNT_EN
      expPk = (k > 3) ? 3 : k;
`else
      expPk = 0;
`endif
      checkOutput("peak_cnt", peak_cnt, expPk);
    end
    @(negedge clk) peak_clr = 1'b1;
    @(negedge clk) peak_clr = 1'b0;
    #1;
    checkOutput("peak_clr", peak_cnt, 0);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
